// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// The optional FETCH_PERF_CNT_EN build adds stall and flush counters to fetch_sequencer.
package fetch_pkg;

  localparam int DEF_ADDR_W  = 10;
  localparam int DEF_INSTR_W = 32;
  localparam int unsigned PC_INC = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_redirect_sel.sv
// Next-PC selection: jump beats branch_taken beats sequential pc+4.
// Redirect targets are forced to a 4-byte boundary.
module fetch_redirect_sel
  import fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_address,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_address,
  output logic [ADDR_W-1:0] next_pc,
  output logic              redirect
);

  // Priority select with alignment masking on the redirect paths.
  always_comb begin
    next_pc  = pc + ADDR_W'(PC_INC);
    redirect = 1'b0;
    if (jump) begin
      next_pc  = {jump_address[ADDR_W-1:2], 2'b00};
      redirect = 1'b1;
    end else if (branch_taken) begin
      next_pc  = {branch_address[ADDR_W-1:2], 2'b00};
      redirect = 1'b1;
    end else begin
      next_pc  = pc + ADDR_W'(PC_INC);
      redirect = 1'b0;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, handshakes with a variable-latency
// imem, buffers one instruction for ID and applies redirects with flush.
// Define FETCH_PERF_CNT_EN to add the perf_stall_cycles / perf_flushes counters.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INSTR_W  = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_address,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  jump_address,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_pc_plus4,
  output logic               flush_ifid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        perf_stall_cycles,
  output logic [15:0]        perf_flushes
`endif
);

  fetch_state_t       state_r;
  fetch_state_t       state_next_s;
  logic [ADDR_W-1:0]  pc_r;
  logic [ADDR_W-1:0]  drain_addr_r;
  logic               if_valid_r;
  logic [INSTR_W-1:0] if_instr_r;
  logic [ADDR_W-1:0]  if_pc_r;
  logic [ADDR_W-1:0]  if_pc_plus4_r;
  logic               flush_r;

  logic [ADDR_W-1:0]  next_pc_s;
  logic               redirect_s;
  logic               can_accept_s;
  logic               req_s;
  logic [ADDR_W-1:0]  addr_s;
  logic               capture_s;
  logic               kill_s;

  fetch_redirect_sel #(.ADDR_W(ADDR_W)) u_redirect_sel (
    .pc             (pc_r),
    .jump           (jump),
    .jump_address   (jump_address),
    .branch_taken   (branch_taken),
    .branch_address (branch_address),
    .next_pc        (next_pc_s),
    .redirect       (redirect_s)
  );

  // A request may only complete into a buffer that is empty or being consumed.
  assign can_accept_s = !if_valid_r || !stall;
  assign capture_s    = (state_r == FETCH) && can_accept_s && imem_ack && !redirect_s;
  assign kill_s       = (state_r == FETCH) && can_accept_s && !imem_ack && redirect_s;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (redirect_s) begin
          state_next_s = en ? FETCH : IDLE;
        end else if (en && can_accept_s) begin
          state_next_s = FETCH;
        end else begin
          state_next_s = IDLE;
        end
      end
      FETCH: begin
        if (kill_s) begin
          state_next_s = DRAIN;
        end else if (redirect_s) begin
          state_next_s = en ? FETCH : IDLE;
        end else if (!can_accept_s) begin
          state_next_s = IDLE;
        end else if (imem_ack) begin
          state_next_s = en ? FETCH : IDLE;
        end else begin
          state_next_s = FETCH;
        end
      end
      DRAIN: begin
        if (imem_ack) begin
          state_next_s = en ? FETCH : IDLE;
        end else begin
          state_next_s = DRAIN;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Output logic: the request is withdrawn while the buffer cannot take data.
  always_comb begin
    req_s  = 1'b0;
    addr_s = pc_r;
    case (state_r)
      IDLE: begin
        req_s  = 1'b0;
        addr_s = pc_r;
      end
      FETCH: begin
        req_s  = can_accept_s;
        addr_s = pc_r;
      end
      DRAIN: begin
        req_s  = 1'b1;
        addr_s = drain_addr_r;
      end
      default: begin
        req_s  = 1'b0;
        addr_s = pc_r;
      end
    endcase
  end

  // PC, drain address, IF/ID buffer and flush pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r          <= RESET_PC;
      drain_addr_r  <= {ADDR_W{1'b0}};
      if_valid_r    <= 1'b0;
      if_instr_r    <= {INSTR_W{1'b0}};
      if_pc_r       <= {ADDR_W{1'b0}};
      if_pc_plus4_r <= {ADDR_W{1'b0}};
      flush_r       <= 1'b0;
    end else begin
      flush_r <= redirect_s;
      if (kill_s) begin
        drain_addr_r <= pc_r;
      end
      if (redirect_s) begin
        pc_r       <= next_pc_s;
        if_valid_r <= 1'b0;
      end else if (capture_s) begin
        pc_r          <= next_pc_s;
        if_valid_r    <= 1'b1;
        if_instr_r    <= imem_rdata;
        if_pc_r       <= pc_r;
        if_pc_plus4_r <= pc_r + ADDR_W'(PC_INC);
      end else if (if_valid_r && !stall) begin
        if_valid_r <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_stall_r;
  logic [15:0] perf_flush_r;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_r <= 16'd0;
      perf_flush_r <= 16'd0;
    end else begin
      if (if_valid_r && stall && (perf_stall_r != 16'hFFFF)) begin
        perf_stall_r <= perf_stall_r + 16'd1;
      end
      if (flush_r && (perf_flush_r != 16'hFFFF)) begin
        perf_flush_r <= perf_flush_r + 16'd1;
      end
    end
  end

  assign perf_stall_cycles = perf_stall_r;
  assign perf_flushes      = perf_flush_r;
`endif

  assign imem_req    = req_s;
  assign imem_addr   = addr_s;
  assign if_valid    = if_valid_r;
  assign if_instr    = if_instr_r;
  assign if_pc       = if_pc_r;
  assign if_pc_plus4 = if_pc_plus4_r;
  assign flush_ifid  = flush_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios followed by random
// traffic, every cycle compared against a behavioural fetch model.
module tb_fetch_sequencer;

  localparam int AW = 10;
  localparam int IW = 32;
  localparam logic [AW-1:0] RPC = 10'h000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, en, stall, branch_taken, jump, imem_ack;
  logic [AW-1:0] branch_address, jump_address;
  logic [IW-1:0] imem_rdata;
  logic          imem_req, if_valid, flush_ifid;
  logic [AW-1:0] imem_addr, if_pc, if_pc_plus4;
  logic [IW-1:0] if_instr;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]   perf_stall_cycles, perf_flushes;
`endif

  fetch_sequencer #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(RPC)) dut (
    .clk            (clk),
    .reset          (reset),
    .en             (en),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_address (branch_address),
    .jump           (jump),
    .jump_address   (jump_address),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .flush_ifid     (flush_ifid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flushes      (perf_flushes)
`endif
  );

  int checks = 0;
  int passed = 0;
  int failed = 0;

  // Reference model: "want" = fetching wanted, "killed" = awaiting ack of a squashed request.
  logic          m_want, m_killed, m_valid, m_flush;
  logic [AW-1:0] m_pc, m_killed_addr, m_if_pc, m_if_pc4;
  logic [IW-1:0] m_instr;
  logic          e_req;
  logic [AW-1:0] e_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RPC; m_want = 1'b0; m_killed = 1'b0; m_killed_addr = '0;
    m_valid = 1'b0; m_instr = '0; m_if_pc = '0; m_if_pc4 = '0; m_flush = 1'b0;
  endtask

  task automatic model_expect();
    if (m_killed) begin
      e_req = 1'b1;
      e_addr = m_killed_addr;
    end else begin
      e_req = m_want && (!m_valid || !stall);
      e_addr = m_pc;
    end
  endtask

  task automatic model_edge();
    logic          redir, got_instr, old_valid;
    logic [AW-1:0] tgt;
    if (reset) begin
      model_reset();
    end else begin
      redir = jump || branch_taken;
      tgt = jump ? jump_address : branch_address;
      tgt[1:0] = 2'b00;
      got_instr = !redir && !m_killed && e_req && imem_ack;
      old_valid = m_valid;
      m_flush = redir;
      if (redir) begin
        if (!m_killed && e_req && !imem_ack) begin
          m_killed = 1'b1;
          m_killed_addr = m_pc;
        end else if (m_killed && imem_ack) begin
          m_killed = 1'b0;
        end
        if (!m_killed) m_want = en;
        m_pc = tgt;
        m_valid = 1'b0;
      end else begin
        if (m_killed) begin
          if (imem_ack) begin
            m_killed = 1'b0;
            m_want = en;
          end
        end else if (m_want) begin
          if (!e_req) m_want = 1'b0;
          else if (imem_ack) m_want = en;
        end else begin
          m_want = en && (!old_valid || !stall);
        end
        if (got_instr) begin
          m_instr = imem_rdata;
          m_if_pc = m_pc;
          m_if_pc4 = m_pc + 10'd4;
          m_valid = 1'b1;
          m_pc = m_pc + 10'd4;
        end else if (old_valid && !stall) begin
          m_valid = 1'b0;
        end
      end
    end
  endtask

  task automatic cycle();
    #1;
    model_expect();
    chk("imem_req", 32'(imem_req), 32'(e_req));
    chk("imem_addr", 32'(imem_addr), 32'(e_addr));
    chk("if_valid", 32'(if_valid), 32'(m_valid));
    chk("if_instr", if_instr, m_instr);
    chk("if_pc", 32'(if_pc), 32'(m_if_pc));
    chk("if_pc_plus4", 32'(if_pc_plus4), 32'(m_if_pc4));
    chk("flush_ifid", 32'(flush_ifid), 32'(m_flush));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step(input logic e, input logic s, input logic j, input logic [AW-1:0] ja,
                      input logic b, input logic [AW-1:0] ba, input logic a, input logic [IW-1:0] rd);
    en = e; stall = s; jump = j; jump_address = ja;
    branch_taken = b; branch_address = ba; imem_ack = a; imem_rdata = rd;
    cycle();
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    jump_address = '0; branch_address = '0; imem_ack = 1'b0; imem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    step(1'b0, 1'b0, 1'b0, 10'h0, 1'b0, 10'h0, 1'b0, 32'h0);
    chk("rst_req", 32'(imem_req), 32'd0);
    reset = 1'b0;

    // Zero-wait fetch
    step(1'b1, 1'b0, 1'b0, 10'h0, 1'b0, 10'h0, 1'b1, 32'h20080005);
    step(1'b1, 1'b0, 1'b0, 10'h0, 1'b0, 10'h0, 1'b1, 32'h20080005);
    chk("zw_pc0", 32'(if_pc), 32'h000);
    chk("zw_instr0", if_instr, 32'h20080005);
    step(1'b1, 1'b0, 1'b0, 10'h0, 1'b0, 10'h0, 1'b1, 32'h20090003);
    chk("zw_pc1", 32'(if_pc), 32'h004);
    chk("zw_pc1p4", 32'(if_pc_plus4), 32'h008);
    step(1'b1, 1'b0, 1'b0, 10'h0, 1'b0, 10'h0, 1'b1, 32'h200A0001);
    chk("zw_pc2", 32'(if_pc), 32'h008);
    chk("zw_pc2p4", 32'(if_pc_plus4), 32'h00C);

    // Variable latency: address held until the ack
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 10'h0, 1'b0, 10'h0, 1'b0, 32'hFFFF0000);
      chk("vl_hold", 32'(imem_addr), 32'h00C);
    end
    step(1'b1, 1'b0, 1'b0, 10'h0, 1'b0, 10'h0, 1'b1, 32'h0000ABCD);
    chk("vl_pc", 32'(if_pc), 32'h00C);
    chk("vl_next", 32'(imem_addr), 32'h010);

    // Stall with a full buffer
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 10'h0, 1'b0, 10'h0, 1'b1, 32'h11111111);
      chk("st_pc", 32'(if_pc), 32'h00C);
      chk("st_instr", if_instr, 32'h0000ABCD);
      chk("st_req", 32'(imem_req), 32'd0);
    end
    step(1'b1, 1'b0, 1'b0, 10'h0, 1'b0, 10'h0, 1'b1, 32'h22222222);
    chk("st_resume_req", 32'(imem_req), 32'd1);
    chk("st_resume_addr", 32'(imem_addr), 32'h010);
    step(1'b1, 1'b0, 1'b0, 10'h0, 1'b0, 10'h0, 1'b1, 32'h33333333);

    // Redirect while a request is outstanding
    repeat (3) step(1'b0, 1'b0, 1'b0, 10'h0, 1'b0, 10'h0, 1'b1, 32'h0);
    step(1'b0, 1'b0, 1'b1, 10'h010, 1'b0, 10'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 10'h0, 1'b0, 10'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 10'h0, 1'b0, 10'h0, 1'b0, 32'h0);
    chk("rd_out_addr", 32'(imem_addr), 32'h010);
    step(1'b1, 1'b0, 1'b0, 10'h0, 1'b1, 10'h0A2, 1'b0, 32'h0);
    chk("rd_flush", 32'(flush_ifid), 32'd1);
    chk("rd_drain_addr", 32'(imem_addr), 32'h010);
    chk("rd_drain_req", 32'(imem_req), 32'd1);
    step(1'b1, 1'b0, 1'b0, 10'h0, 1'b0, 10'h0, 1'b1, 32'hBAD0BAD0);
    chk("rd_new_addr", 32'(imem_addr), 32'h0A0);
    chk("rd_flush_end", 32'(flush_ifid), 32'd0);
    chk("rd_discard", 32'(if_valid), 32'd0);

    // Jump and branch together with a same-cycle ack
    step(1'b1, 1'b0, 1'b1, 10'h100, 1'b1, 10'h200, 1'b1, 32'hDEADBEEF);
    chk("jb_addr", 32'(imem_addr), 32'h100);
    chk("jb_valid", 32'(if_valid), 32'd0);
    chk("jb_flush", 32'(flush_ifid), 32'd1);

    // PC wrap at the top of the address space
    repeat (3) step(1'b0, 1'b0, 1'b0, 10'h0, 1'b0, 10'h0, 1'b1, 32'h0);
    step(1'b0, 1'b0, 1'b1, 10'h3FE, 1'b0, 10'h0, 1'b0, 32'h0);
    chk("wr_align", 32'(imem_addr), 32'h3FC);
    step(1'b1, 1'b0, 1'b0, 10'h0, 1'b0, 10'h0, 1'b1, 32'h0);
    chk("wr_req", 32'(imem_req), 32'd1);
    step(1'b1, 1'b0, 1'b0, 10'h0, 1'b0, 10'h0, 1'b1, 32'h12345678);
    chk("wr_next", 32'(imem_addr), 32'h000);
    chk("wr_ifpc", 32'(if_pc), 32'h3FC);
    chk("wr_pc4", 32'(if_pc_plus4), 32'h000);

    // Reset in the middle of an outstanding request
    step(1'b1, 1'b0, 1'b0, 10'h0, 1'b0, 10'h0, 1'b0, 32'h0);
    reset = 1'b1;
    step(1'b1, 1'b0, 1'b0, 10'h0, 1'b0, 10'h0, 1'b0, 32'h0);
    reset = 1'b0;
    chk("mr_req", 32'(imem_req), 32'd0);
    chk("mr_valid", 32'(if_valid), 32'd0);
    chk("mr_pc", 32'(imem_addr), 32'(RPC));

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      reset = ($urandom % 100) == 0;
      step(($urandom % 8) != 0, ($urandom % 4) == 0, ($urandom % 20) == 0,
           AW'($urandom), ($urandom % 16) == 0, AW'($urandom),
           ($urandom % 2) == 0, $urandom);
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
